// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD subtractor: state encoding and BCD digit limits.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         BCD_RADIX = 10;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  function automatic logic bcd_invalid(input logic [3:0] dig);
    return dig > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtractor: d = a - b - bin with ten's-complement correction on borrow.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout,
  output logic       err
);

  logic [5:0] t;

  always_comb begin
    t    = {2'b00, a} - {2'b00, b} - {5'b0_0000, bin};
    bout = t[5];
    // Negative raw difference: fold back into 0..9 by adding the radix.
    d    = t[5] ? 4'(t + 6'(BCD_RADIX)) : t[3:0];
    err  = bcd_invalid(a) | bcd_invalid(b);
  end

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor, LSD first: one shared digit slice, start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start; results held
//   RUN   | one digit per cycle, idx 0..DIGITS-1
//   DONE  | done pulse; d/bout/err valid
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   d,
  output logic                  bout,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, d_q, d_d;
  logic          brw_q, brw_d;
  logic          bout_q, bout_d;
  logic          err_q, err_d;

  logic [3:0]    dig_a, dig_b, dig_d;
  logic          dig_bout, dig_err;
  logic          in_err;

  bcd_digit_sub u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .bin  (brw_q),
    .d    (dig_d),
    .bout (dig_bout),
    .err  (dig_err)
  );

  always_comb begin
    dig_a  = 4'h0;
    dig_b  = 4'h0;
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
      in_err = in_err | bcd_invalid(a[4*i +: 4]) | bcd_invalid(b[4*i +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          d_d     = '0;
          bout_d  = 1'b0;
          err_d   = in_err;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IW'(i)) d_d[4*i +: 4] = dig_d;
        end
        brw_d = dig_bout;
        err_d = err_q | dig_err;
        if (idx_q == LAST) begin
          bout_d  = dig_bout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Self-checking bench for bcd_serial_sub (DIGITS=4) against a decimal-arithmetic reference.
module tb_bcd_serial_sub;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, bin;
  logic        busy, done, bout, err;
  logic [15:0] a, b, d;
  logic [15:0] got;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_serial_sub #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .err   (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r += int'(v[4*i +: 4]) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x /= 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [15:0] v);
    logic bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad |= (v[4*i +: 4] > 4'd9);
    return bad;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(9));
    return r;
  endfunction

  // Called right after a falling edge; returns right after the falling edge following done.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                        input bit ign, input bit chk_d, output logic [15:0] got_d);
    int          diff;
    logic [15:0] exp_d;
    logic        exp_b, exp_e;
    int          cyc, nbusy;
    diff  = bcd2int(ta) - bcd2int(tb_) - int'(tbin);
    exp_b = (diff < 0);
    if (diff < 0) diff += 10000;
    exp_d = int2bcd(diff);
    exp_e = has_bad(ta) | has_bad(tb_);

    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    cyc = 0; nbusy = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (busy) nbusy++;
      if (ign && (cyc == 2 || cyc == DIGITS + 1)) begin
        start = 1'b1; a = rand_bcd(); b = rand_bcd(); bin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done || cyc >= 20) break;
    end
    chk("latency", cyc, DIGITS + 1);
    chk("busy_cycles", nbusy, DIGITS + 1);
    chk("err", {31'b0, err}, {31'b0, exp_e});
    if (chk_d) begin
      chk("d", {16'b0, d}, {16'b0, exp_d});
      chk("bout", {31'b0, bout}, {31'b0, exp_b});
    end
    got_d = d;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("idle_after_done", {31'b0, busy}, 32'd0);
    if (chk_d) chk("d_hold", {16'b0, d}, {16'b0, exp_d});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_d", {16'b0, d}, 32'd0);
    chk("rst_bout", {31'b0, bout}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h5432, 16'h1234, 1'b0, 0, 1, got);
    chk("dir_5432_1234", {16'b0, got}, 32'h4198);
    run_op(16'h0000, 16'h0001, 1'b0, 0, 1, got);
    chk("dir_0_1", {16'b0, got}, 32'h9999);
    chk("dir_0_1_bout", {31'b0, bout}, 32'd1);
    run_op(16'h1000, 16'h0001, 1'b1, 0, 1, got);
    chk("dir_1000_1_b1", {16'b0, got}, 32'h0998);
    run_op(16'h0000, 16'h0000, 1'b1, 0, 1, got);
    chk("dir_0_0_b1", {16'b0, got}, 32'h9999);
    chk("dir_0_0_b1_bout", {31'b0, bout}, 32'd1);

    // start pulses during RUN and DONE must be dropped
    run_op(16'h2222, 16'h1111, 1'b0, 1, 1, got);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_second_done", {31'b0, done}, 32'd0);
      chk("no_second_busy", {31'b0, busy}, 32'd0);
    end
    chk("ign_result", {16'b0, d}, 32'h1111);

    // previous op left bout=1; abort a run holding err=1 and partial digits
    run_op(16'h0000, 16'h0001, 1'b0, 0, 1, got);
    a = 16'h5A32; b = 16'h1234; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    chk("pre_rst_err", {31'b0, err}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_d", {16'b0, d}, 32'd0);
    chk("abort_bout", {31'b0, bout}, 32'd0);
    chk("abort_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h7305, 16'h2918, 1'b1, 0, 1, got);
    chk("post_rst", {16'b0, got}, 32'h4386);

    run_op(16'h00A0, 16'h0001, 1'b0, 0, 0, got);
    chk("bad_digit_err", {31'b0, err}, 32'd1);
    chk("bad_digit_d", {16'b0, got}, 32'h0099);
    run_op(16'h0042, 16'h0013, 1'b0, 0, 1, got);
    chk("err_cleared", {31'b0, err}, 32'd0);

    for (int n = 0; n < 30; n++) begin
      run_op(rand_bcd(), rand_bcd(), 1'($urandom), 0, 1, got);
    end
    for (int n = 0; n < 10; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 0, 0, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
